// File: rtl/core_sequencer_if.sv
// Host/core-facing signal bundle for core_sequencer: configuration and start
// from the host, OFIFO status from the core, instruction word and status out.
interface core_sequencer_if #(
  parameter int addr_bw = 11
);
  logic               start;
  logic [addr_bw-1:0] w_base;
  logic [addr_bw-1:0] x_base;
  logic [addr_bw-1:0] psum_base;
  logic [addr_bw-1:0] num_x;
  logic               acc;
  logic               ofifo_valid;
  logic [33:0]        inst;
  logic               busy;
  logic               done;

  modport master (
    output start, w_base, x_base, psum_base, num_x, acc, ofifo_valid,
    input  inst, busy, done
  );

  modport slave (
    input  start, w_base, x_base, psum_base, num_x, acc, ofifo_valid,
    output inst, busy, done
  );
endinterface

// File: rtl/core_sequencer.sv
// Emits the registered 34-bit instruction stream for one weight-stationary
// tile pass: weight load, weight shift-in, activation load, execute, drain, PSUM write-back.
module core_sequencer #(
  parameter int row      = 8,
  parameter int col      = 8,
  parameter int addr_bw  = 11,
  parameter int load_gap = row + col
) (
  input  logic            clk,
  input  logic            reset,
  core_sequencer_if.slave bus
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_W_L0,
    S_W_LOAD,
    S_W_GAP,
    S_X_L0,
    S_X_EXEC,
    S_DRAIN,
    S_PSUM_WR,
    S_DONE
  } state_e;

  localparam int B_ACC   = 33;
  localparam int B_PCEN  = 32;
  localparam int B_PWEN  = 31;
  localparam int B_PADDR = 20;
  localparam int B_XCEN  = 19;
  localparam int B_XWEN  = 18;
  localparam int B_XADDR = 7;
  localparam int B_OFRD  = 6;
  localparam int B_L0RD  = 3;
  localparam int B_L0WR  = 2;
  localparam int B_EXEC  = 1;
  localparam int B_LOAD  = 0;

  localparam logic [33:0] IDLE_WORD = (34'd1 << B_PCEN) | (34'd1 << B_PWEN) |
                                      (34'd1 << B_XCEN) | (34'd1 << B_XWEN);

  localparam logic [addr_bw-1:0] COL_LAST  = addr_bw'(col);
  localparam logic [addr_bw-1:0] LOAD_LAST = addr_bw'(col - 1);
  localparam logic [addr_bw-1:0] GAP_LAST  = addr_bw'(load_gap - 1);

  state_e             state_q, state_d;
  logic [addr_bw-1:0] cnt_q, cnt_d;
  logic [addr_bw-1:0] rd_cnt_q, rd_cnt_d;
  logic [addr_bw-1:0] wr_cnt_q, wr_cnt_d;
  logic [addr_bw-1:0] w_base_q, w_base_d;
  logic [addr_bw-1:0] x_base_q, x_base_d;
  logic [addr_bw-1:0] psum_base_q, psum_base_d;
  logic [addr_bw-1:0] num_x_q, num_x_d;
  logic               acc_q, acc_d;
  logic [33:0]        inst_q, inst_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               rd_fire, wr_fire;

  // Next state and counters first; the instruction word is then built from
  // the *next* state so the registered inst lines up with state_q each cycle.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + 1'b1;
    rd_cnt_d    = rd_cnt_q;
    wr_cnt_d    = wr_cnt_q;
    w_base_d    = w_base_q;
    x_base_d    = x_base_q;
    psum_base_d = psum_base_q;
    num_x_d     = num_x_q;
    acc_d       = acc_q;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (bus.start) begin
          state_d     = S_W_L0;
          rd_cnt_d    = '0;
          wr_cnt_d    = '0;
          w_base_d    = bus.w_base;
          x_base_d    = bus.x_base;
          psum_base_d = bus.psum_base;
          num_x_d     = bus.num_x;
          acc_d       = bus.acc;
        end
      end
      S_W_L0: begin
        if (cnt_q == COL_LAST) begin
          state_d = S_W_LOAD;
          cnt_d   = '0;
        end
      end
      S_W_LOAD: begin
        if (cnt_q == LOAD_LAST) begin
          state_d = S_W_GAP;
          cnt_d   = '0;
        end
      end
      S_W_GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = (num_x_q != '0) ? S_X_L0 : S_DONE;
          cnt_d   = '0;
        end
      end
      S_X_L0: begin
        if (cnt_q == num_x_q) begin
          state_d = S_X_EXEC;
          cnt_d   = '0;
        end
      end
      S_X_EXEC: begin
        if (cnt_q == num_x_q - 1'b1) begin
          state_d = S_DRAIN;
          cnt_d   = '0;
        end
      end
      S_DRAIN: begin
        cnt_d = '0;
        if (bus.ofifo_valid) state_d = S_PSUM_WR;
      end
      S_PSUM_WR: begin
        cnt_d = '0;
        if (wr_cnt_q == num_x_q) state_d = S_DONE;
      end
      S_DONE: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase

    // Each OFIFO read issued last cycle becomes a PSUM write this cycle.
    wr_fire = (state_q == S_PSUM_WR) && inst_q[B_OFRD];
    rd_fire = (state_d == S_PSUM_WR) && bus.ofifo_valid && (rd_cnt_q < num_x_q);
    if (rd_fire) rd_cnt_d = rd_cnt_q + 1'b1;
    if (wr_fire) wr_cnt_d = wr_cnt_q + 1'b1;

    inst_d = IDLE_WORD;
    case (state_d)
      S_W_L0: begin
        if (cnt_d < COL_LAST) begin
          inst_d[B_XCEN]              = 1'b0;
          inst_d[B_XADDR +: addr_bw]  = w_base_d + cnt_d;
        end
        inst_d[B_L0WR] = (cnt_d != '0);
      end
      S_W_LOAD: begin
        inst_d[B_L0RD] = 1'b1;
        inst_d[B_LOAD] = 1'b1;
      end
      S_X_L0: begin
        if (cnt_d < num_x_d) begin
          inst_d[B_XCEN]              = 1'b0;
          inst_d[B_XADDR +: addr_bw]  = x_base_d + cnt_d;
        end
        inst_d[B_L0WR] = (cnt_d != '0);
      end
      S_X_EXEC: begin
        inst_d[B_L0RD] = 1'b1;
        inst_d[B_EXEC] = 1'b1;
      end
      S_PSUM_WR: begin
        inst_d[B_OFRD] = rd_fire;
        if (wr_fire) begin
          inst_d[B_PCEN]              = 1'b0;
          inst_d[B_PWEN]              = 1'b0;
          inst_d[B_PADDR +: addr_bw]  = psum_base_d + wr_cnt_q;
          inst_d[B_ACC]               = acc_d;
        end
      end
      default: ;
    endcase

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      rd_cnt_q    <= '0;
      wr_cnt_q    <= '0;
      w_base_q    <= '0;
      x_base_q    <= '0;
      psum_base_q <= '0;
      num_x_q     <= '0;
      acc_q       <= 1'b0;
      inst_q      <= IDLE_WORD;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rd_cnt_q    <= rd_cnt_d;
      wr_cnt_q    <= wr_cnt_d;
      w_base_q    <= w_base_d;
      x_base_q    <= x_base_d;
      psum_base_q <= psum_base_d;
      num_x_q     <= num_x_d;
      acc_q       <= acc_d;
      inst_q      <= inst_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign bus.inst = inst_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_core_sequencer.sv
// Scoreboard bench for core_sequencer: expected XMEM/PSUM addresses are queued
// when a pass is launched and popped by a cycle monitor as the DUT issues them.
module tb_core_sequencer;
  localparam int AW  = 11;
  localparam int COL = 8;
  localparam int GAP = 16;
  localparam logic [33:0] IDLE_W = 34'h1_800C_0000;

  logic clk = 1'b0;
  logic reset;

  core_sequencer_if #(.addr_bw(AW)) bus ();

  core_sequencer #(
    .row(8), .col(COL), .addr_bw(AW), .load_gap(GAP)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [AW-1:0] exp_x[$];
  logic [AW-1:0] exp_p[$];
  logic          exp_acc = 1'b0;

  int n_load = 0, n_exec = 0, n_l0wr = 0, n_done = 0, n_ofrd = 0, n_pw = 0;
  int cyc = 0, last_load = 0, gap_dist = -1;
  bit saw_load, prev_xread, prev_ofrd, prev_valid, prev_done;

  bit       vpat_en = 1'b0;
  int       pidx = 0;
  logic [3:0] vpat = 4'b1001;

  // OFIFO valid: held high, or cycling 1,0,0,1 during the bubble scenario.
  always @(posedge clk) begin
    #1;
    if (vpat_en) begin
      bus.ofifo_valid = vpat[pidx];
      pidx = (pidx + 1) % 4;
    end else begin
      bus.ofifo_valid = 1'b1;
    end
  end

  always @(negedge clk) begin : monitor
    logic [33:0]   w;
    logic [AW-1:0] e;
    bit            xread, pw;
    w = bus.inst;
    cyc++;
    if (reset) begin
      prev_xread = 0; prev_ofrd = 0; prev_valid = 0; prev_done = 0; saw_load = 0;
    end else begin
      xread = (w[19] == 1'b0);
      if (xread) begin
        checks++;
        if (exp_x.size() == 0) begin
          errors++;
          $display("FAIL xmem_read unexpected: got addr=%0d, required no read", w[17:7]);
        end else begin
          e = exp_x.pop_front();
          if (w[17:7] !== e || w[18] !== 1'b1) begin
            errors++;
            $display("FAIL xmem_read: got addr=%0d wen=%b, required addr=%0d wen=1", w[17:7], w[18], e);
          end
        end
        if (saw_load) begin
          gap_dist = cyc - last_load;
          saw_load = 0;
        end
      end
      if (w[2] || prev_xread) begin
        checks++;
        if (w[2] !== prev_xread) begin
          errors++;
          $display("FAIL l0_wr_lag: got l0_wr=%b, required %b", w[2], prev_xread);
        end
      end
      if (w[2]) n_l0wr++;
      if (w[0]) begin n_load++; last_load = cyc; saw_load = 1; end
      if (w[1]) n_exec++;
      if (w[6]) begin
        n_ofrd++;
        checks++;
        if (prev_valid !== 1'b1) begin
          errors++;
          $display("FAIL ofifo_rd_without_valid: got valid=%b, required 1", prev_valid);
        end
      end
      pw = (w[32] == 1'b0);
      if (pw || prev_ofrd) begin
        checks++;
        if (pw !== prev_ofrd) begin
          errors++;
          $display("FAIL psum_wr_lag: got write=%b, required %b", pw, prev_ofrd);
        end
      end
      if (pw) begin
        n_pw++;
        checks++;
        if (exp_p.size() == 0) begin
          errors++;
          $display("FAIL psum_write unexpected: got addr=%0d, required no write", w[30:20]);
        end else begin
          e = exp_p.pop_front();
          if (w[30:20] !== e || w[31] !== 1'b0 || w[33] !== exp_acc) begin
            errors++;
            $display("FAIL psum_write: got addr=%0d wen=%b acc=%b, required addr=%0d wen=0 acc=%b",
                     w[30:20], w[31], w[33], e, exp_acc);
          end
        end
      end
      if (bus.done) begin
        n_done++;
        checks++;
        if (bus.busy !== 1'b1) begin
          errors++;
          $display("FAIL done_busy: got busy=%b, required 1", bus.busy);
        end
      end
      if (prev_done) begin
        checks++;
        if (bus.busy !== 1'b0 || w !== IDLE_W) begin
          errors++;
          $display("FAIL after_done: got busy=%b inst=%h, required busy=0 inst=%h", bus.busy, w, IDLE_W);
        end
      end
      prev_xread = xread;
      prev_ofrd  = w[6];
      prev_valid = bus.ofifo_valid;
      prev_done  = bus.done;
    end
  end

  task automatic push_pass(input logic [AW-1:0] wb, xb, pb, nx);
    logic [AW-1:0] a;
    for (int unsigned k = 0; k < COL; k++) begin a = wb + AW'(k); exp_x.push_back(a); end
    for (int unsigned k = 0; k < nx; k++) begin a = xb + AW'(k); exp_x.push_back(a); end
    for (int unsigned k = 0; k < nx; k++) begin a = pb + AW'(k); exp_p.push_back(a); end
  endtask

  task automatic pulse_start(input logic [AW-1:0] wb, xb, pb, nx, input logic a);
    @(posedge clk); #1;
    bus.w_base = wb; bus.x_base = xb; bus.psum_base = pb; bus.num_x = nx;
    bus.acc = a; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int i = 0;
    @(negedge clk);
    while (bus.busy && i < budget) begin @(negedge clk); i++; end
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    bus.start = 1'b0; bus.acc = 1'b0;
    bus.w_base = '0; bus.x_base = '0; bus.psum_base = '0; bus.num_x = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.inst !== IDLE_W) begin errors++; $display("FAIL reset_inst: got %h, required %h", bus.inst, IDLE_W); end
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, required 0", bus.busy); end
    checks++;
    if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b, required 0", bus.done); end
    @(negedge clk); #2;
    reset = 1'b0;
  endtask

  task automatic test_main;
    int l0 = n_load, e0 = n_exec, w0 = n_l0wr, d0 = n_done, p0 = n_pw, r0 = n_ofrd;
    exp_acc = 1'b0;
    push_pass(11'd0, 11'd8, 11'd100, 11'd4);
    pulse_start(11'd0, 11'd8, 11'd100, 11'd4, 1'b0);
    wait_idle(300);
    checks++;
    if (n_load - l0 != COL) begin errors++; $display("FAIL main_loads: got %0d, required %0d", n_load - l0, COL); end
    checks++;
    if (n_l0wr - w0 != COL + 4) begin errors++; $display("FAIL main_l0wr: got %0d, required %0d", n_l0wr - w0, COL + 4); end
    checks++;
    if (gap_dist != GAP + 1) begin errors++; $display("FAIL main_gap: got %0d, required %0d", gap_dist, GAP + 1); end
    checks++;
    if (n_exec - e0 != 4) begin errors++; $display("FAIL main_exec: got %0d, required 4", n_exec - e0); end
    checks++;
    if (n_ofrd - r0 != 4) begin errors++; $display("FAIL main_ofrd: got %0d, required 4", n_ofrd - r0); end
    checks++;
    if (n_pw - p0 != 4) begin errors++; $display("FAIL main_pw: got %0d, required 4", n_pw - p0); end
    checks++;
    if (n_done - d0 != 1) begin errors++; $display("FAIL main_done: got %0d, required 1", n_done - d0); end
    checks++;
    if (exp_x.size() + exp_p.size() != 0) begin
      errors++; $display("FAIL main_left: got %0d pending, required 0", exp_x.size() + exp_p.size());
    end
  endtask

  task automatic test_zero;
    int l0 = n_load, e0 = n_exec, d0 = n_done, p0 = n_pw, r0 = n_ofrd;
    exp_acc = 1'b0;
    push_pass(11'd20, 11'd500, 11'd7, 11'd0);
    pulse_start(11'd20, 11'd500, 11'd7, 11'd0, 1'b0);
    wait_idle(300);
    checks++;
    if (n_load - l0 != COL) begin errors++; $display("FAIL zero_loads: got %0d, required %0d", n_load - l0, COL); end
    checks++;
    if (n_exec - e0 != 0) begin errors++; $display("FAIL zero_exec: got %0d, required 0", n_exec - e0); end
    checks++;
    if (n_pw - p0 != 0 || n_ofrd - r0 != 0) begin
      errors++; $display("FAIL zero_psum: got writes=%0d reads=%0d, required 0", n_pw - p0, n_ofrd - r0);
    end
    checks++;
    if (n_done - d0 != 1) begin errors++; $display("FAIL zero_done: got %0d, required 1", n_done - d0); end
    checks++;
    if (exp_x.size() != 0) begin errors++; $display("FAIL zero_left: got %0d pending, required 0", exp_x.size()); end
  endtask

  task automatic test_wrap;
    int d0 = n_done, p0 = n_pw;
    exp_acc = 1'b0;
    push_pass(11'd2044, 11'd2046, 11'd2047, 11'd4);
    pulse_start(11'd2044, 11'd2046, 11'd2047, 11'd4, 1'b0);
    wait_idle(300);
    checks++;
    if (n_pw - p0 != 4) begin errors++; $display("FAIL wrap_pw: got %0d, required 4", n_pw - p0); end
    checks++;
    if (n_done - d0 != 1) begin errors++; $display("FAIL wrap_done: got %0d, required 1", n_done - d0); end
    checks++;
    if (exp_x.size() + exp_p.size() != 0) begin
      errors++; $display("FAIL wrap_left: got %0d pending, required 0", exp_x.size() + exp_p.size());
    end
  endtask

  task automatic test_bubbles;
    int d0 = n_done, p0 = n_pw, r0 = n_ofrd;
    exp_acc = 1'b0;
    vpat_en = 1'b1;
    push_pass(11'd0, 11'd16, 11'd50, 11'd4);
    pulse_start(11'd0, 11'd16, 11'd50, 11'd4, 1'b0);
    wait_idle(400);
    vpat_en = 1'b0;
    checks++;
    if (n_ofrd - r0 != 4) begin errors++; $display("FAIL bubble_ofrd: got %0d, required 4", n_ofrd - r0); end
    checks++;
    if (n_pw - p0 != 4) begin errors++; $display("FAIL bubble_pw: got %0d, required 4", n_pw - p0); end
    checks++;
    if (n_done - d0 != 1) begin errors++; $display("FAIL bubble_done: got %0d, required 1", n_done - d0); end
    checks++;
    if (exp_p.size() != 0) begin errors++; $display("FAIL bubble_left: got %0d pending, required 0", exp_p.size()); end
  endtask

  task automatic test_back_to_back;
    int d0 = n_done, p0 = n_pw;
    exp_acc = 1'b1;
    push_pass(11'd40, 11'd60, 11'd300, 11'd4);
    pulse_start(11'd40, 11'd60, 11'd300, 11'd4, 1'b1);
    repeat (3) @(posedge clk);
    pulse_start(11'd400, 11'd500, 11'd600, 11'd2, 1'b1);
    wait_idle(300);
    repeat (10) @(negedge clk);
    #1;
    checks++;
    if (n_done - d0 != 1) begin errors++; $display("FAIL b2b_done: got %0d, required 1", n_done - d0); end
    checks++;
    if (n_pw - p0 != 4) begin errors++; $display("FAIL b2b_pw: got %0d, required 4", n_pw - p0); end
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL b2b_busy: got %b, required 0", bus.busy); end
    checks++;
    if (exp_x.size() + exp_p.size() != 0) begin
      errors++; $display("FAIL b2b_left: got %0d pending, required 0", exp_x.size() + exp_p.size());
    end
    exp_acc = 1'b0;
  endtask

  task automatic test_reset_midpass;
    int e0 = n_exec, d0 = n_done, i = 0;
    exp_acc = 1'b0;
    push_pass(11'd0, 11'd8, 11'd0, 11'd4);
    pulse_start(11'd0, 11'd8, 11'd0, 11'd4, 1'b0);
    while (n_exec == e0 && i < 200) begin @(negedge clk); i++; end
    checks++;
    if (n_exec == e0) begin errors++; $display("FAIL midreset_reach_exec: got 0 exec cycles, required >0"); end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %b, required 0", bus.busy); end
    checks++;
    if (bus.inst !== IDLE_W) begin errors++; $display("FAIL midreset_inst: got %h, required %h", bus.inst, IDLE_W); end
    checks++;
    if (bus.done !== 1'b0) begin errors++; $display("FAIL midreset_done: got %b, required 0", bus.done); end
    exp_x.delete();
    exp_p.delete();
    repeat (2) @(negedge clk);
    #3 reset = 1'b0;
    repeat (20) @(negedge clk);
    #1;
    checks++;
    if (n_done != d0) begin errors++; $display("FAIL midreset_no_done: got %0d, required %0d", n_done, d0); end
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL midreset_idle: got busy=%b, required 0", bus.busy); end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_main();
    test_zero();
    test_wrap();
    test_bubbles();
    test_back_to_back();
    test_reset_midpass();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
